serial_bridge: RTL and testbench
================================

# serial_bridge

Parametrised byte bridge between the USB CDC serial core's strobe/ready byte interface and the UART transmitter/receiver pair, replacing the ad-hoc glue in the demo tops. It buffers each direction in its own FIFO and holds traffic off for a power-up interval. It also provides bridge, test-pattern and loopback modes. It sits in the 12 MHz system-clock domain, between `usb_serial` and `uart_tx`/`uart_rx`.

## Interface

- `WIDTH`, 8: byte width on all data ports.
- `DEPTH_LOG2`, 4: log2 FIFO depth. Each direction holds 2^DEPTH_LOG2 entries.
- `STARTUP_CYCLES`, 2^24-1: hold-off cycles after reset before any traffic.
- `PATTERN_BASE`, 8'h41: first pattern byte ("A").
- `PATTERN_LEN`, 26: number of pattern bytes before the index wraps. Must be 1..2^WIDTH.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `mode`  in  2  traffic mode: 0 bridge, 1 pattern, 2 loopback, 3 treated as bridge.
- `clear_flags`  in  1  one-cycle pulse; clears both overflow flags.
- `host_rx_strobe`  in  1  byte from host valid (one-cycle pulse).
- `host_rx_data`  in  WIDTH  byte from host.
- `host_tx_ready`  in  1  USB core can accept a byte.
- `host_tx_strobe`  out  1  byte to host (one-cycle pulse).
- `host_tx_data`  out  WIDTH  byte to host.
- `uart_rx_strobe`  in  1  byte from UART receiver valid.
- `uart_rx_data`  in  WIDTH  byte from UART receiver.
- `uart_tx_ready`  in  1  UART transmitter idle.
- `uart_tx_strobe`  out  1  byte to UART transmitter (one-cycle pulse).
- `uart_tx_data`  out  WIDTH  byte to UART transmitter.
- `active`  out  1  hold-off complete.
- `h2u_level`, `u2h_level`  out  DEPTH_LOG2+1  FIFO occupancy.
- `h2u_overflow`, `u2h_overflow`  out  1  sticky overflow flags.

## Operation

- **Reset:** while `reset_n`=0, every output, FIFO pointer, pattern index and hold-off counter is 0. FIFO contents are discarded. Deassertion restarts the hold-off, and reset asserted mid-operation takes effect immediately.
- **Hold-off:** the counter increments each cycle while `active`=0. `active` rises on the cycle after the counter reaches STARTUP_CYCLES and stays high until reset. While `active`=0, input strobes are ignored and no output strobe is issued.
- **FIFOs:** `h2u` feeds the UART output and `u2h` feeds the host output. The push source depends on `mode`:
  - **Bridge:** `host_rx` pushes to `h2u`; `uart_rx` pushes to `u2h`.
  - **Loopback:** `host_rx` pushes to `u2h`; `uart_rx` pushes to `h2u`.
  - **Pattern:** the generator pushes byte PATTERN_BASE+idx into both FIFOs, only on cycles when neither FIFO is full. idx increments and wraps from PATTERN_LEN-1 to 0. Input strobes are discarded and do not count as overflow.
- **Mode changes:** take effect on the next edge. FIFO contents are kept and drain normally.
- **Overflow:** a push to a full FIFO with no pop in the same cycle drops the byte and sets that FIFO's overflow flag. A push with a simultaneous pop on a full FIFO is accepted and the level is unchanged.
- **Flag clear:** `clear_flags` clears both flags. If an overflow and `clear_flags` occur in the same cycle, the overflow wins and the flag stays 1.
- **Output handshake, per side:** pop and assert strobe when all of the following hold:
  - `active`=1;
  - the FIFO is non-empty;
  - ready=1;
  - strobe was 0 on the previous cycle.

  This enforces a minimum one-idle-cycle gap between strobes, because ready lags strobe by one cycle. Data is registered with the strobe and held until the next strobe.
- **Pointers:** DEPTH_LOG2+1 bits each, wrapping modulo 2^(DEPTH_LOG2+1). Full is when the MSBs differ and the rest are equal; empty is when the pointers are equal.

## Timing

- Input strobe at edge N: the FIFO write is visible at N+1, and the earliest output strobe is at N+1. Minimum latency is 1 cycle.
- Maximum output rate is one byte per 2 cycles per side.
- Level outputs are registered and update on the edge after a push or pop.
- Pattern mode with both outputs always ready produces one byte per 2 cycles on each side, identical sequences on both.
- Both directions are independent and can strobe in the same cycle.

## Test plan

- **Hold-off:** STARTUP_CYCLES=10, pulse `host_rx_strobe` at cycle 5 -> byte dropped, no overflow flag, `active` rises at cycle 11, `h2u_level`=0.
- **Bridge:** send 0x55 from host with `uart_tx_ready`=1 -> `uart_tx_strobe` 1 cycle later with `uart_tx_data`=0x55. Send 0xA3 from UART -> 0xA3 strobed to host.
- **Overflow:** DEPTH_LOG2=2, `uart_tx_ready`=0, push 5 bytes -> `h2u_level`=4, `h2u_overflow`=1, and bytes 1-4 drain in order. `clear_flags` then clears the flag.
- **Pattern:** PATTERN_LEN=3, both ready -> both sides emit 0x41,0x42,0x43,0x41, spaced 2 cycles apart.
- **Loopback:** host sends 0x10,0x11 -> host receives 0x10,0x11 and `uart_tx_strobe` stays 0.
- **Reset mid-transfer:** `reset_n` low with 3 bytes queued -> all outputs 0 immediately, levels 0, and hold-off restarts.

Source files
------------

// File: rtl/serial_bridge.sv
// Byte bridge between the USB serial core and the UART pair: one FIFO per
// direction, power-up hold-off, and bridge / test-pattern / loopback modes.

module serial_bridge_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  active,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  clear_flag,
  input  logic                  ready,
  output logic                  full,
  output logic                  strobe,
  output logic [WIDTH-1:0]      data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr, rptr;
  logic empty, pop, push_ok, overflow_event;

  assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                 (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign empty = (wptr == rptr);

  // Strobe must be low for a cycle before the next pop, since ready lags strobe.
  assign pop            = active && !empty && ready && !strobe;
  assign push_ok        = push && (!full || pop);
  assign overflow_event = push && full && !pop;

  // NOTE: the storage array has no reset; contents are meaningless until the
  // write pointer passes them, and leaving it out keeps it in plain RAM cells.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[DEPTH_LOG2-1:0]] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      strobe   <= 1'b0;
      data     <= '0;
      overflow <= 1'b0;
    end else begin
      strobe <= pop;
      if (pop) begin
        data <= mem[rptr[DEPTH_LOG2-1:0]];
        rptr <= rptr + 1'b1;
      end
      if (push_ok) wptr <= wptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (overflow_event)  overflow <= 1'b1;
      else if (clear_flag) overflow <= 1'b0;
    end
  end

endmodule

module serial_bridge #(
  parameter int                 WIDTH          = 8,
  parameter int                 DEPTH_LOG2     = 4,
  parameter int unsigned        STARTUP_CYCLES = 32'(2**24 - 1),
  parameter logic [WIDTH-1:0]   PATTERN_BASE   = WIDTH'(8'h41),
  parameter int                 PATTERN_LEN    = 26
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic                  clear_flags,
  input  logic                  host_rx_strobe,
  input  logic [WIDTH-1:0]      host_rx_data,
  input  logic                  host_tx_ready,
  output logic                  host_tx_strobe,
  output logic [WIDTH-1:0]      host_tx_data,
  input  logic                  uart_rx_strobe,
  input  logic [WIDTH-1:0]      uart_rx_data,
  input  logic                  uart_tx_ready,
  output logic                  uart_tx_strobe,
  output logic [WIDTH-1:0]      uart_tx_data,
  output logic                  active,
  output logic [DEPTH_LOG2:0]   h2u_level,
  output logic [DEPTH_LOG2:0]   u2h_level,
  output logic                  h2u_overflow,
  output logic                  u2h_overflow
);

  typedef enum logic [1:0] {
    MODE_BRIDGE   = 2'd0,
    MODE_PATTERN  = 2'd1,
    MODE_LOOPBACK = 2'd2,
    MODE_BRIDGE_B = 2'd3
  } mode_e;

  localparam int CNT_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARTUP_CYCLES);
  localparam logic [WIDTH-1:0] IDX_LAST = WIDTH'(PATTERN_LEN - 1);

  logic [CNT_W-1:0] holdoff_cnt;
  logic [WIDTH-1:0] pat_idx;
  logic [WIDTH-1:0] pat_byte;
  logic             pat_push;
  logic             h2u_push, u2h_push, h2u_full, u2h_full;
  logic [WIDTH-1:0] h2u_din, u2h_din;

  // The counter stops at its terminal value, so a full 2^N-1 hold-off fits N bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holdoff_cnt <= '0;
      active      <= 1'b0;
    end else if (!active) begin
      if (holdoff_cnt == CNT_LAST) active <= 1'b1;
      else                         holdoff_cnt <= holdoff_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pat_idx <= '0;
    else if (pat_push) pat_idx <= (pat_idx == IDX_LAST) ? '0 : pat_idx + 1'b1;
  end

  assign pat_byte = PATTERN_BASE + pat_idx;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    pat_push = 1'b0;
    h2u_push = 1'b0;
    u2h_push = 1'b0;
    h2u_din  = host_rx_data;
    u2h_din  = uart_rx_data;
    if (active) begin
      case (mode_e'(mode))
        MODE_PATTERN: begin
          // Pushing only when both have room keeps the two streams identical.
          pat_push = !h2u_full && !u2h_full;
          h2u_push = pat_push;
          u2h_push = pat_push;
          h2u_din  = pat_byte;
          u2h_din  = pat_byte;
        end
        MODE_LOOPBACK: begin
          h2u_push = uart_rx_strobe;
          h2u_din  = uart_rx_data;
          u2h_push = host_rx_strobe;
          u2h_din  = host_rx_data;
        end
        default: begin
          h2u_push = host_rx_strobe;
          u2h_push = uart_rx_strobe;
        end
      endcase
    end
  end

  serial_bridge_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_h2u (
    .clk        (clk),
    .reset_n    (reset_n),
    .active     (active),
    .push       (h2u_push),
    .push_data  (h2u_din),
    .clear_flag (clear_flags),
    .ready      (uart_tx_ready),
    .full       (h2u_full),
    .strobe     (uart_tx_strobe),
    .data       (uart_tx_data),
    .level      (h2u_level),
    .overflow   (h2u_overflow)
  );

  serial_bridge_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_u2h (
    .clk        (clk),
    .reset_n    (reset_n),
    .active     (active),
    .push       (u2h_push),
    .push_data  (u2h_din),
    .clear_flag (clear_flags),
    .ready      (host_tx_ready),
    .full       (u2h_full),
    .strobe     (host_tx_strobe),
    .data       (host_tx_data),
    .level      (u2h_level),
    .overflow   (u2h_overflow)
  );

endmodule

// File: tb/tb_serial_bridge.sv
// Scoreboard bench for serial_bridge: stimulus queues expected bytes per side,
// a negedge monitor pops and compares whenever an output strobe appears.

module tb_serial_bridge;

  localparam int W  = 8;
  localparam int DL = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    mode;
  logic          clear_flags;
  logic          host_rx_strobe;
  logic [W-1:0]  host_rx_data;
  logic          host_tx_ready;
  logic          host_tx_strobe;
  logic [W-1:0]  host_tx_data;
  logic          uart_rx_strobe;
  logic [W-1:0]  uart_rx_data;
  logic          uart_tx_ready;
  logic          uart_tx_strobe;
  logic [W-1:0]  uart_tx_data;
  logic          active;
  logic [DL:0]   h2u_level, u2h_level;
  logic          h2u_overflow, u2h_overflow;

  serial_bridge #(
    .WIDTH(W), .DEPTH_LOG2(DL), .STARTUP_CYCLES(10),
    .PATTERN_BASE(8'h41), .PATTERN_LEN(3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mode           (mode),
    .clear_flags    (clear_flags),
    .host_rx_strobe (host_rx_strobe),
    .host_rx_data   (host_rx_data),
    .host_tx_ready  (host_tx_ready),
    .host_tx_strobe (host_tx_strobe),
    .host_tx_data   (host_tx_data),
    .uart_rx_strobe (uart_rx_strobe),
    .uart_rx_data   (uart_rx_data),
    .uart_tx_ready  (uart_tx_ready),
    .uart_tx_strobe (uart_tx_strobe),
    .uart_tx_data   (uart_tx_data),
    .active         (active),
    .h2u_level      (h2u_level),
    .u2h_level      (u2h_level),
    .h2u_overflow   (h2u_overflow),
    .u2h_overflow   (u2h_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int uart_cnt = 0;
  logic [W-1:0] exp_uart[$];
  logic [W-1:0] exp_host[$];
  logic pattern_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_send(input logic [W-1:0] b);
    host_rx_data   = b;
    host_rx_strobe = 1'b1;
    tick(1);
    host_rx_strobe = 1'b0;
  endtask

  task automatic uart_send(input logic [W-1:0] b);
    uart_rx_data   = b;
    uart_rx_strobe = 1'b1;
    tick(1);
    uart_rx_strobe = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each output strobe against the head of its queue.
  logic prev_u = 1'b0, prev_h = 1'b0;
  int   u_last = -1, h_last = -1;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_u = 1'b0;
      prev_h = 1'b0;
    end else begin
      if (uart_tx_strobe) begin
        uart_cnt++;
        if (exp_uart.size() == 0) begin
          checks++; errors++;
          $display("FAIL uart_unexpected: got %02h, expected no strobe (t=%0t)", uart_tx_data, $time);
        end else check("uart_data", 32'(uart_tx_data), 32'(exp_uart.pop_front()));
        check("uart_gap", 32'(prev_u), 32'd0);
        if (pattern_phase && u_last >= 0) check("uart_spacing", 32'(cyc - u_last), 32'd2);
        u_last = cyc;
      end
      if (host_tx_strobe) begin
        if (exp_host.size() == 0) begin
          checks++; errors++;
          $display("FAIL host_unexpected: got %02h, expected no strobe (t=%0t)", host_tx_data, $time);
        end else check("host_data", 32'(host_tx_data), 32'(exp_host.pop_front()));
        check("host_gap", 32'(prev_h), 32'd0);
        if (pattern_phase && h_last >= 0) check("host_spacing", 32'(cyc - h_last), 32'd2);
        h_last = cyc;
      end
      prev_u = uart_tx_strobe;
      prev_h = host_tx_strobe;
    end
    if (!pattern_phase) begin
      u_last = -1;
      h_last = -1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    reset_n = 1'b0; mode = 2'd0; clear_flags = 1'b0;
    host_rx_strobe = 1'b0; host_rx_data = '0; host_tx_ready = 1'b1;
    uart_rx_strobe = 1'b0; uart_rx_data = '0; uart_tx_ready = 1'b1;
    #12;
    check("rst_active", 32'(active), 32'd0);
    check("rst_h2u_level", 32'(h2u_level), 32'd0);
    check("rst_u2h_level", 32'(u2h_level), 32'd0);
    check("rst_strobes", 32'({uart_tx_strobe, host_tx_strobe}), 32'd0);

    // Hold-off: a host byte at cycle 5 is dropped without flagging overflow.
    @(posedge clk); #1; reset_n = 1'b1;
    tick(4);
    host_send(8'hC7);
    check("holdoff_level", 32'(h2u_level), 32'd0);
    check("holdoff_ovf", 32'(h2u_overflow), 32'd0);
    tick(5);
    check("holdoff_active_c10", 32'(active), 32'd0);
    tick(1);
    check("holdoff_active_c11", 32'(active), 32'd1);
    check("holdoff_level_after", 32'(h2u_level), 32'd0);

    // Bridge both directions with one-cycle latency.
    exp_uart.push_back(8'h55);
    host_send(8'h55);
    check("bridge_h2u_level", 32'(h2u_level), 32'd1);
    tick(1);
    check("bridge_uart_strobe", 32'(uart_tx_strobe), 32'd1);
    exp_host.push_back(8'hA3);
    uart_send(8'hA3);
    tick(1);
    check("bridge_host_strobe", 32'(host_tx_strobe), 32'd1);
    tick(3);

    // Overflow on a 4-deep FIFO with the UART stalled.
    uart_tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_uart.push_back(W'(i));
      host_send(W'(i));
      tick(1);
    end
    check("ovf_level", 32'(h2u_level), 32'd4);
    check("ovf_flag", 32'(h2u_overflow), 32'd1);
    check("ovf_other_flag", 32'(u2h_overflow), 32'd0);
    clear_flags = 1'b1;
    host_send(8'h06);
    clear_flags = 1'b0;
    check("ovf_wins_clear", 32'(h2u_overflow), 32'd1);
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    check("ovf_cleared", 32'(h2u_overflow), 32'd0);
    uart_tx_ready = 1'b1;
    tick(10);
    check("ovf_drained", 32'(h2u_level), 32'd0);

    // Pattern mode for exactly four pushes; a host byte meanwhile is discarded.
    for (int i = 0; i < 4; i++) begin
      exp_uart.push_back(8'h41 + W'(i % 3));
      exp_host.push_back(8'h41 + W'(i % 3));
    end
    pattern_phase = 1'b1;
    mode = 2'd1;
    tick(1);
    host_rx_data = 8'hEE; host_rx_strobe = 1'b1;
    tick(1);
    host_rx_strobe = 1'b0;
    tick(2);
    mode = 2'd0;
    tick(10);
    pattern_phase = 1'b0;
    check("pat_h2u_ovf", 32'(h2u_overflow), 32'd0);
    check("pat_u2h_ovf", 32'(u2h_overflow), 32'd0);
    check("pat_levels", 32'({h2u_level, u2h_level}), 32'd0);

    // Loopback: host bytes return to host, nothing toward the UART.
    mode = 2'd2;
    snap = uart_cnt;
    exp_host.push_back(8'h10);
    exp_host.push_back(8'h11);
    host_send(8'h10);
    tick(1);
    host_send(8'h11);
    tick(6);
    check("loop_no_uart", 32'(uart_cnt), 32'(snap));
    mode = 2'd0;

    // Reset mid-transfer with three bytes queued.
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_send(8'h31 + W'(i));
      tick(1);
    end
    check("rst_mid_level_before", 32'(h2u_level), 32'd3);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_active", 32'(active), 32'd0);
    check("rst_mid_levels", 32'({h2u_level, u2h_level}), 32'd0);
    check("rst_mid_data", 32'({uart_tx_data, host_tx_data}), 32'd0);
    check("rst_mid_strobes", 32'({uart_tx_strobe, host_tx_strobe}), 32'd0);
    #10;
    @(posedge clk); #1;
    reset_n = 1'b1;
    uart_tx_ready = 1'b1;
    tick(10);
    check("rst_holdoff_c10", 32'(active), 32'd0);
    tick(1);
    check("rst_holdoff_c11", 32'(active), 32'd1);
    check("rst_level_after", 32'(h2u_level), 32'd0);
    exp_uart.push_back(8'h99);
    host_send(8'h99);
    tick(4);

    check("uart_queue_empty", 32'(exp_uart.size()), 32'd0);
    check("host_queue_empty", 32'(exp_host.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
